// File: rtl/uart_ntt_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_ntt_frame_loader
// Description : Turns framed UART bytes (base, length, payload words) into
//               twiddle/data RAM writes for the NTT core. It checks the frame
//               length, enforces an inter-byte timeout, refuses writes while
//               the core is busy, and pulses ntt_start after a good frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_ntt_frame_loader #(
  parameter int W            = 32,
  parameter int RADIX        = 16,
  parameter int TIMEOUT_CLKS = 20000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_dv_i,
  input  logic [7:0]                 rx_byte_i,
  input  logic                       ntt_busy_i,
  output logic                       tw_we_o,
  output logic [$clog2(RADIX/2)-1:0] tw_addr_o,
  output logic [W-1:0]               tw_data_o,
  output logic                       dat_we_o,
  output logic [$clog2(RADIX)-1:0]   dat_addr_o,
  output logic [W-1:0]               dat_data_o,
  output logic                       ntt_start_o,
  output logic                       busy_o,
  output logic                       err_o,
  output logic [1:0]                 err_code_o
);

  localparam int NB     = W / 8;
  localparam int HALF   = RADIX / 2;
  localparam int NPTS   = 3 * RADIX / 2;
  localparam int TW_AW  = $clog2(HALF);
  localparam int DAT_AW = $clog2(RADIX);
  localparam int IW     = $clog2(NPTS + 1);
  localparam int BCW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int TCW    = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [W:0] NPTS_EXT = NPTS;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_BUSY    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR_BASE = 3'd1,
    S_HDR_LEN  = 3'd2,
    S_PAYLOAD  = 3'd3,
    S_START    = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  state_t          state, state_n;
  logic [BCW-1:0]  byte_cnt;
  logic [W-1:0]    word_reg;
  logic [W-1:0]    asm_word;
  logic [W-1:0]    base_reg;
  logic [W-1:0]    remaining;
  logic [IW-1:0]   idx;
  logic [TCW-1:0]  tcnt;
  logic [W:0]      len_sum;
  logic            word_done;
  logic            collecting;
  logic            in_timed;
  logic            expire;
  logic            len_bad;
  logic            do_write;
  logic            raise_err;
  logic [1:0]      err_val;

  // Word under assembly with the incoming byte dropped into its little-endian slot
  always_comb begin
    asm_word = word_reg;
    for (int k = 0; k < NB; k++) begin
      if (byte_cnt == BCW'(k)) asm_word[8*k +: 8] = rx_byte_i;
    end
  end

  assign word_done  = rx_dv_i && (byte_cnt == BCW'(NB - 1));
  assign collecting = (state == S_IDLE) || (state == S_HDR_BASE) ||
                      (state == S_HDR_LEN) || (state == S_PAYLOAD);
  assign in_timed   = (state == S_HDR_BASE) || (state == S_HDR_LEN) ||
                      (state == S_PAYLOAD) || (state == S_ERROR);
  assign expire     = in_timed && !rx_dv_i && (tcnt == TCW'(TIMEOUT_CLKS - 1));
  // Base + length is formed one bit wider so a huge base cannot wrap past the check
  assign len_sum    = {1'b0, base_reg} + {1'b0, asm_word};
  assign len_bad    = (asm_word == '0) || (len_sum > NPTS_EXT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state decode, write/error decisions and busy flag
  always_comb begin
    state_n   = state;
    do_write  = 1'b0;
    raise_err = 1'b0;
    err_val   = 2'd0;
    busy_o    = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (rx_dv_i) state_n = word_done ? S_HDR_LEN : S_HDR_BASE;
      end
      S_HDR_BASE: begin
        if (expire) begin
          raise_err = 1'b1; err_val = ERR_TIMEOUT; state_n = S_IDLE;
        end else if (word_done) begin
          state_n = S_HDR_LEN;
        end
      end
      S_HDR_LEN: begin
        if (expire) begin
          raise_err = 1'b1; err_val = ERR_TIMEOUT; state_n = S_IDLE;
        end else if (word_done) begin
          if (len_bad) begin
            raise_err = 1'b1; err_val = ERR_LEN; state_n = S_ERROR;
          end else begin
            state_n = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (expire) begin
          raise_err = 1'b1; err_val = ERR_TIMEOUT; state_n = S_IDLE;
        end else if (word_done) begin
          if (ntt_busy_i) begin
            raise_err = 1'b1; err_val = ERR_BUSY; state_n = S_ERROR;
          end else begin
            do_write = 1'b1;
            if (remaining == W'(1)) state_n = S_START;
          end
        end
      end
      S_START: state_n = S_IDLE;
      S_ERROR: begin
        if (expire) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: byte assembly, header capture, RAM writes, timeout and error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt    <= '0;
      word_reg    <= '0;
      base_reg    <= '0;
      remaining   <= '0;
      idx         <= '0;
      tcnt        <= '0;
      tw_we_o     <= 1'b0;
      tw_addr_o   <= '0;
      tw_data_o   <= '0;
      dat_we_o    <= 1'b0;
      dat_addr_o  <= '0;
      dat_data_o  <= '0;
      ntt_start_o <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= 2'd0;
    end else begin
      tw_we_o     <= 1'b0;
      dat_we_o    <= 1'b0;
      ntt_start_o <= 1'b0;

      if (rx_dv_i || (state != state_n) || !in_timed) tcnt <= '0;
      else                                             tcnt <= tcnt + 1'b1;

      // Any exit from collection discards a partially assembled word
      if (!collecting || word_done || (state_n == S_IDLE) ||
          (state_n == S_START) || (state_n == S_ERROR)) begin
        byte_cnt <= '0;
        word_reg <= '0;
      end else if (rx_dv_i) begin
        byte_cnt <= byte_cnt + 1'b1;
        word_reg <= asm_word;
      end

      if (word_done && ((state == S_IDLE) || (state == S_HDR_BASE))) base_reg <= asm_word;

      if (word_done && (state == S_HDR_LEN)) begin
        remaining <= asm_word;
        idx       <= base_reg[IW-1:0];
      end

      if (do_write) begin
        if (idx < IW'(HALF)) begin
          tw_we_o   <= 1'b1;
          tw_addr_o <= idx[TW_AW-1:0];
          tw_data_o <= asm_word;
        end else begin
          dat_we_o   <= 1'b1;
          dat_addr_o <= idx[DAT_AW-1:0] - DAT_AW'(HALF);
          dat_data_o <= asm_word;
        end
        idx       <= idx + 1'b1;
        remaining <= remaining - 1'b1;
      end

      if (raise_err) begin
        err_o      <= 1'b1;
        err_code_o <= err_val;
      end

      if (state == S_START) begin
        ntt_start_o <= 1'b1;
        err_o       <= 1'b0;
        err_code_o  <= 2'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_ntt_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_ntt_frame_loader
// Description : Self-checking bench for uart_ntt_frame_loader: table-driven
//               frames, randomized frames against a frame-level model, and
//               hand-written timeout / bad-length / mid-frame reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_ntt_frame_loader;

  localparam int W    = 32;
  localparam int RADIX = 16;
  localparam int TO   = 40;
  localparam int HALF = RADIX / 2;
  localparam int NPTS = 3 * RADIX / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        ntt_busy = 1'b0;
  logic        tw_we_o, dat_we_o, ntt_start_o, busy_o, err_o;
  logic [2:0]  tw_addr_o;
  logic [3:0]  dat_addr_o;
  logic [W-1:0] tw_data_o, dat_data_o;
  logic [1:0]  err_code_o;

  always #5 clk = ~clk;

  uart_ntt_frame_loader #(.W(W), .RADIX(RADIX), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst(rst), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte), .ntt_busy_i(ntt_busy),
    .tw_we_o(tw_we_o), .tw_addr_o(tw_addr_o), .tw_data_o(tw_data_o),
    .dat_we_o(dat_we_o), .dat_addr_o(dat_addr_o), .dat_data_o(dat_data_o),
    .ntt_start_o(ntt_start_o), .busy_o(busy_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  typedef struct {
    bit           is_dat;
    int           addr;
    logic [W-1:0] data;
    int           cyc;
  } wr_t;

  typedef struct {
    logic [W-1:0] base;
    logic [W-1:0] len;
    int           busy_at;
    int           gap;
    int           fixed;
    int           exp_code;
    int           exp_start;
  } vec_t;

  wr_t          obs[$];
  vec_t         tbl [0:12];
  logic [W-1:0] pw [0:NPTS-1];
  int checks = 0, errors = 0, cyc = 0, starts = 0, start_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Record every RAM write and start pulse seen by the NTT side
  always @(negedge clk) begin : mon
    wr_t w;
    if (!rst) begin
      if (tw_we_o || dat_we_o) begin
        check("we_onehot", 64'(tw_we_o & dat_we_o), 64'd0);
        w.is_dat = dat_we_o;
        w.addr   = dat_we_o ? int'(dat_addr_o) : int'(tw_addr_o);
        w.data   = dat_we_o ? dat_data_o : tw_data_o;
        w.cyc    = cyc;
        obs.push_back(w);
      end
      if (ntt_start_o) begin
        starts++;
        start_cyc = cyc;
      end
    end
  end

  task automatic put_byte(input logic [7:0] b, input int gap);
    rx_dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    for (int k = 0; k < W/8; k++) put_byte(w[8*k +: 8], gap);
  endtask

  // Frame-level outcome: 1 bad length, 3 busy collision, 0 good
  function automatic int model_code(input logic [W-1:0] b, input logic [W-1:0] l, input int busy_at);
    if (l == '0 || (longint'(b) + longint'(l)) > longint'(NPTS)) return 1;
    if (busy_at >= 0 && busy_at < int'(l)) return 3;
    return 0;
  endfunction

  task automatic run_frame(input vec_t v);
    wr_t exp_q[$];
    wr_t e;
    int  nwr, idx;
    obs.delete();
    starts = 0;
    send_word(v.base, v.gap);
    send_word(v.len, v.gap);
    if (v.exp_code != 1) begin
      for (int j = 0; j < int'(v.len); j++) begin
        ntt_busy = (j == v.busy_at);
        send_word(pw[j], v.gap);
      end
    end
    ntt_busy = 1'b0;
    repeat (4) @(negedge clk);
    nwr = (v.exp_code == 0) ? int'(v.len) : ((v.exp_code == 3) ? v.busy_at : 0);
    for (int j = 0; j < nwr; j++) begin
      idx      = int'(v.base) + j;
      e.is_dat = (idx >= HALF);
      e.addr   = (idx >= HALF) ? idx - HALF : idx;
      e.data   = pw[j];
      e.cyc    = 0;
      exp_q.push_back(e);
    end
    check("n_writes", 64'(obs.size()), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < obs.size(); j++) begin
      check("wr_ram", 64'(obs[j].is_dat), 64'(exp_q[j].is_dat));
      check("wr_addr", 64'(obs[j].addr), 64'(exp_q[j].addr));
      check("wr_data", 64'(obs[j].data), 64'(exp_q[j].data));
    end
    check("n_starts", 64'(starts), 64'(v.exp_start));
    if (v.exp_start != 0 && obs.size() > 0)
      check("start_lat", 64'(start_cyc - obs[obs.size()-1].cyc), 64'd1);
    check("err_o", 64'(err_o), 64'(v.exp_code != 0));
    check("err_code", 64'(err_code_o), 64'(v.exp_code));
    if (v.exp_code == 1 || v.exp_code == 3) repeat (TO) @(negedge clk);
    check("idle_after", 64'(busy_o), 64'd0);
  endtask

  task automatic fill_payload(input int fixed);
    for (int j = 0; j < NPTS; j++) pw[j] = $urandom;
    if (fixed == 1) begin
      pw[0]  = 32'h000015C1;
      pw[7]  = 32'h000015C1;
      pw[15] = 32'h00001803;
    end else if (fixed == 2) begin
      pw[0] = 32'hAAAA5555;
      pw[1] = 32'h12345678;
    end
  endtask

  initial begin
    vec_t v;
    int b, l, bz;

    tbl[0]  = '{base:32'd0,  len:32'd24, busy_at:-1, gap:1, fixed:1, exp_code:0, exp_start:1};
    tbl[1]  = '{base:32'd10, len:32'd2,  busy_at:-1, gap:1, fixed:2, exp_code:0, exp_start:1};
    tbl[2]  = '{base:32'd20, len:32'd8,  busy_at:-1, gap:1, fixed:0, exp_code:1, exp_start:0};
    tbl[3]  = '{base:32'd10, len:32'd2,  busy_at:-1, gap:2, fixed:2, exp_code:0, exp_start:1};
    tbl[4]  = '{base:32'd10, len:32'd2,  busy_at:0,  gap:1, fixed:2, exp_code:3, exp_start:0};
    tbl[5]  = '{base:32'd10, len:32'd2,  busy_at:-1, gap:0, fixed:2, exp_code:0, exp_start:1};
    tbl[6]  = '{base:32'd0,  len:32'd0,  busy_at:-1, gap:0, fixed:0, exp_code:1, exp_start:0};
    tbl[7]  = '{base:32'd23, len:32'd1,  busy_at:-1, gap:1, fixed:0, exp_code:0, exp_start:1};
    tbl[8]  = '{base:32'd8,  len:32'd16, busy_at:-1, gap:0, fixed:0, exp_code:0, exp_start:1};
    tbl[9]  = '{base:32'd7,  len:32'd2,  busy_at:-1, gap:0, fixed:0, exp_code:0, exp_start:1};
    tbl[10] = '{base:32'd24, len:32'd1,  busy_at:-1, gap:1, fixed:0, exp_code:1, exp_start:0};
    tbl[11] = '{base:32'hFFFFFFFF, len:32'd2, busy_at:-1, gap:1, fixed:0, exp_code:1, exp_start:0};
    tbl[12] = '{base:32'd2,  len:32'd6,  busy_at:3,  gap:0, fixed:0, exp_code:3, exp_start:0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({tw_we_o, dat_we_o, ntt_start_o, busy_o, err_o, err_code_o}), 64'd0);
    check("rst_addr", 64'({tw_addr_o, dat_addr_o}), 64'd0);
    check("rst_data", {tw_data_o, dat_data_o}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      fill_payload(tbl[i].fixed);
      run_frame(tbl[i]);
    end

    // Timeout inside a payload word: err 2 exactly TO clocks after the last byte
    fill_payload(2);
    run_frame(tbl[1]);
    obs.delete();
    send_word(32'd0, 1);
    send_word(32'd4, 1);
    put_byte(8'h11, 0);
    put_byte(8'h22, 0);
    repeat (TO - 1) @(negedge clk);
    check("to_early_code", 64'(err_code_o), 64'd0);
    check("to_early_busy", 64'(busy_o), 64'd1);
    @(negedge clk);
    check("to_code", 64'(err_code_o), 64'd2);
    check("to_err", 64'(err_o), 64'd1);
    check("to_busy", 64'(busy_o), 64'd0);
    check("to_nowrite", 64'(obs.size()), 64'd0);

    // Bad length flagged right after the last header byte, then ERROR drains
    send_word(32'd20, 1);
    send_word(32'd8, 0);
    check("bl_code", 64'(err_code_o), 64'd1);
    check("bl_busy", 64'(busy_o), 64'd1);
    repeat (TO - 1) @(negedge clk);
    check("bl_hold", 64'(busy_o), 64'd1);
    @(negedge clk);
    check("bl_idle", 64'(busy_o), 64'd0);
    fill_payload(2);
    run_frame(tbl[1]);

    // Reset in the middle of a back-to-back payload
    obs.delete();
    send_word(32'd10, 0);
    send_word(32'd2, 0);
    send_word(32'hCAFEF00D, 0);
    put_byte(8'h01, 0);
    put_byte(8'h02, 0);
    rst = 1'b1;
    #1;
    check("mr_ctrl", 64'({tw_we_o, dat_we_o, ntt_start_o, busy_o, err_o, err_code_o}), 64'd0);
    check("mr_data", {tw_data_o, dat_data_o}, 64'd0);
    check("mr_writes", 64'(obs.size()), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mr_nowrite", 64'(obs.size()), 64'd1);
    fill_payload(2);
    run_frame(tbl[5]);

    // Randomized frames against the frame-level model
    for (int r = 0; r < 12; r++) begin
      b  = int'($urandom_range(0, 26));
      l  = int'($urandom_range(0, 10));
      bz = -1;
      if (l > 0 && $urandom_range(0, 3) == 0) bz = int'($urandom_range(0, l - 1));
      v.base      = W'(b);
      v.len       = W'(l);
      v.busy_at   = bz;
      v.gap       = int'($urandom_range(0, 2));
      v.fixed     = 0;
      v.exp_code  = model_code(v.base, v.len, bz);
      v.exp_start = (v.exp_code == 0) ? 1 : 0;
      fill_payload(0);
      run_frame(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
